// File: rtl/vwb_serializer_pkg.sv
// -----------------------------------------------------------------------------
// vwb_serializer_pkg
// Shared definitions for the vector writeback serializer:
//   - default configuration values and the derived-size helpers used by the
//     top level (NUMLANES, WIDTH, NUMGROUPS, GRPIDW)
//   - the drain FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package vwb_serializer_pkg;

    // Default configuration of the block
    localparam int DEF_LOG2WIDTH    = 5;
    localparam int DEF_LOG2NUMLANES = 4;
    localparam int DEF_NUMWBLANES   = 4;
    localparam int DEF_REGIDWIDTH   = 4;

    // FSM encoding: IDLE waits for a vector, DRAIN writes one group per cycle
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int calc_numlanes(input int log2numlanes);
        return 2 ** log2numlanes;
    endfunction

    function automatic int calc_width(input int log2width);
        return 2 ** log2width;
    endfunction

    function automatic int calc_numgroups(input int numlanes, input int numwblanes);
        return numlanes / numwblanes;
    endfunction

    // Group index needs at least one bit even when there is a single group
    function automatic int calc_grpidw(input int numgroups);
        return (numgroups > 1) ? $clog2(numgroups) : 1;
    endfunction

    // Derived sizes for the default configuration
    localparam int NUMLANES  = calc_numlanes(DEF_LOG2NUMLANES);
    localparam int WIDTH     = calc_width(DEF_LOG2WIDTH);
    localparam int NUMGROUPS = calc_numgroups(NUMLANES, DEF_NUMWBLANES);
    localparam int GRPIDW    = calc_grpidw(NUMGROUPS);

endpackage

// File: rtl/vwb_groupsel.sv
// -----------------------------------------------------------------------------
// vwb_groupsel
// Combinational live-group finder. Reduces a lane mask to one live bit per
// lane group and returns the lowest live group strictly above after_idx.
// after_idx is signed so that -1 searches from group 0 upward.
// Ports:
//   mask      in  NUMLANES   lane write-enable mask
//   after_idx in  GRPIDW+1   signed start index (exclusive), -1 = from start
//   next_idx  out GRPIDW     lowest live group above after_idx
//   found     out 1          a live group above after_idx exists
// -----------------------------------------------------------------------------
module vwb_groupsel
    import vwb_serializer_pkg::*;
#(
    parameter int NUMLANES   = vwb_serializer_pkg::NUMLANES,
    parameter int NUMWBLANES = DEF_NUMWBLANES,
    parameter int NUMGROUPS  = vwb_serializer_pkg::NUMGROUPS,
    parameter int GRPIDW     = vwb_serializer_pkg::GRPIDW
) (
    input  logic [NUMLANES-1:0]      mask,
    input  logic signed [GRPIDW:0]   after_idx,
    output logic [GRPIDW-1:0]        next_idx,
    output logic                     found
);

    logic [NUMGROUPS-1:0] live;

    always_comb begin
        live = '0;
        for (int g = 0; g < NUMGROUPS; g++) begin
            live[g] = |mask[g*NUMWBLANES +: NUMWBLANES];
        end
    end

    // Scanning downward lets the lowest qualifying group win
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int g = NUMGROUPS - 1; g >= 0; g--) begin
            if (live[g] && (g > int'(after_idx))) begin
                next_idx = GRPIDW'(g);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vwb_serializer.sv
// -----------------------------------------------------------------------------
// vwb_serializer
// Vector writeback serializer. Captures one full vector result and writes it to
// the register file one NUMWBLANES-wide lane group per cycle, skipping groups
// whose mask is all zero. Upstream is stalled while more groups remain.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid             result vector present
//   in_dst               destination register
//   in_mask              per-lane write enable
//   in_result            lane i at [i*WIDTH +: WIDTH]
//   flush                synchronous discard of the in-flight vector
//   stall                upstream must hold in_* this cycle
//   busy                 a vector is being drained
//   wb_we/wb_dst/wb_group/wb_mask/wb_data   register-file write port
// -----------------------------------------------------------------------------
module vwb_serializer
    import vwb_serializer_pkg::*;
#(
    parameter  int LOG2WIDTH    = DEF_LOG2WIDTH,
    parameter  int LOG2NUMLANES = DEF_LOG2NUMLANES,
    parameter  int NUMWBLANES   = DEF_NUMWBLANES,
    parameter  int REGIDWIDTH   = DEF_REGIDWIDTH,
    localparam int NUMLANES     = calc_numlanes(LOG2NUMLANES),
    localparam int WIDTH        = calc_width(LOG2WIDTH),
    localparam int NUMGROUPS    = calc_numgroups(NUMLANES, NUMWBLANES),
    localparam int GRPIDW       = calc_grpidw(NUMGROUPS)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           in_valid,
    input  logic [REGIDWIDTH-1:0]          in_dst,
    input  logic [NUMLANES-1:0]            in_mask,
    input  logic [NUMLANES*WIDTH-1:0]      in_result,
    input  logic                           flush,
    output logic                           stall,
    output logic                           busy,
    output logic                           wb_we,
    output logic [REGIDWIDTH-1:0]          wb_dst,
    output logic [GRPIDW-1:0]              wb_group,
    output logic [NUMWBLANES-1:0]          wb_mask,
    output logic [NUMWBLANES*WIDTH-1:0]    wb_data
);

    localparam int GRPW = NUMWBLANES * WIDTH;

    state_t                     state;
    logic [GRPIDW-1:0]          ptr;
    logic [REGIDWIDTH-1:0]      held_dst;
    logic [NUMLANES-1:0]        held_mask;
    logic [NUMLANES*WIDTH-1:0]  held_data;

    logic [GRPIDW-1:0]          first_idx;
    logic                       first_found;
    logic [GRPIDW-1:0]          more_idx;
    logic                       more_found;
    logic signed [GRPIDW:0]     from_start;
    logic signed [GRPIDW:0]     after_ptr;

    assign from_start = '1;
    assign after_ptr  = $signed({1'b0, ptr});

    // First live group of the offered vector, used when it is accepted
    vwb_groupsel #(
        .NUMLANES   (NUMLANES),
        .NUMWBLANES (NUMWBLANES),
        .NUMGROUPS  (NUMGROUPS),
        .GRPIDW     (GRPIDW)
    ) u_first_sel (
        .mask      (in_mask),
        .after_idx (from_start),
        .next_idx  (first_idx),
        .found     (first_found)
    );

    // Next live group of the held vector beyond the one being written now
    vwb_groupsel #(
        .NUMLANES   (NUMLANES),
        .NUMWBLANES (NUMWBLANES),
        .NUMGROUPS  (NUMGROUPS),
        .GRPIDW     (GRPIDW)
    ) u_next_sel (
        .mask      (held_mask),
        .after_idx (after_ptr),
        .next_idx  (more_idx),
        .found     (more_found)
    );

    // stall depends only on registered state so it never loops back to in_valid
    assign stall = (state == DRAIN) && more_found;
    assign busy  = (state == DRAIN);

    // Drain FSM with registered write-port outputs. The write for a group is
    // loaded on the edge that selects it, so the first write of an accepted
    // vector appears the cycle right after acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            held_dst  <= '0;
            held_mask <= '0;
            held_data <= '0;
            wb_we     <= 1'b0;
            wb_dst    <= '0;
            wb_group  <= '0;
            wb_mask   <= '0;
            wb_data   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            ptr       <= '0;
            held_mask <= '0;
            wb_we     <= 1'b0;
            wb_dst    <= '0;
            wb_group  <= '0;
            wb_mask   <= '0;
            wb_data   <= '0;
        end else if ((state == DRAIN) && more_found) begin
            ptr      <= more_idx;
            wb_we    <= 1'b1;
            wb_dst   <= held_dst;
            wb_group <= more_idx;
            wb_mask  <= held_mask[more_idx*NUMWBLANES +: NUMWBLANES];
            wb_data  <= held_data[more_idx*GRPW +: GRPW];
        end else if (in_valid) begin
            // Either idle or on the last group: stall is low, so accept
            held_dst  <= in_dst;
            held_mask <= in_mask;
            held_data <= in_result;
            if (first_found) begin
                state    <= DRAIN;
                ptr      <= first_idx;
                wb_we    <= 1'b1;
                wb_dst   <= in_dst;
                wb_group <= first_idx;
                wb_mask  <= in_mask[first_idx*NUMWBLANES +: NUMWBLANES];
                wb_data  <= in_result[first_idx*GRPW +: GRPW];
            end else begin
                state    <= IDLE;
                ptr      <= '0;
                wb_we    <= 1'b0;
                wb_dst   <= '0;
                wb_group <= '0;
                wb_mask  <= '0;
                wb_data  <= '0;
            end
        end else begin
            state    <= IDLE;
            ptr      <= '0;
            wb_we    <= 1'b0;
            wb_dst   <= '0;
            wb_group <= '0;
            wb_mask  <= '0;
            wb_data  <= '0;
        end
    end

endmodule

// File: tb/tb_vwb_serializer.sv
// -----------------------------------------------------------------------------
// tb_vwb_serializer
// Directed and random stimulus for vwb_serializer, checked against a queue of
// expected register-file writes derived from each accepted vector.
// -----------------------------------------------------------------------------
module tb_vwb_serializer;

    localparam int LOG2WIDTH    = 5;
    localparam int LOG2NUMLANES = 4;
    localparam int NUMWBLANES   = 4;
    localparam int REGIDWIDTH   = 4;
    localparam int NUMLANES     = 16;
    localparam int WIDTH        = 32;
    localparam int NUMGROUPS    = 4;
    localparam int GRPIDW       = 2;
    localparam int GW           = NUMWBLANES * WIDTH;

    logic                         clk = 1'b0;
    logic                         resetn;
    logic                         in_valid;
    logic [REGIDWIDTH-1:0]        in_dst;
    logic [NUMLANES-1:0]          in_mask;
    logic [NUMLANES*WIDTH-1:0]    in_result;
    logic                         flush;
    logic                         stall;
    logic                         busy;
    logic                         wb_we;
    logic [REGIDWIDTH-1:0]        wb_dst;
    logic [GRPIDW-1:0]            wb_group;
    logic [NUMWBLANES-1:0]        wb_mask;
    logic [GW-1:0]                wb_data;

    vwb_serializer #(
        .LOG2WIDTH    (LOG2WIDTH),
        .LOG2NUMLANES (LOG2NUMLANES),
        .NUMWBLANES   (NUMWBLANES),
        .REGIDWIDTH   (REGIDWIDTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_dst    (in_dst),
        .in_mask   (in_mask),
        .in_result (in_result),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .wb_we     (wb_we),
        .wb_dst    (wb_dst),
        .wb_group  (wb_group),
        .wb_mask   (wb_mask),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    // One expected register-file write
    typedef struct {
        logic [REGIDWIDTH-1:0] dst;
        logic [GRPIDW-1:0]     grp;
        logic [NUMWBLANES-1:0] mask;
        logic [GW-1:0]         data;
    } wr_t;

    wr_t exp_q[$];
    int  n_asserts = 0;
    int  n_fail = 0;
    int  accepted_last = 0;

    task automatic check_eq(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // A vector expands into one write per group with any lane enabled, in order
    task automatic model_push(input logic [REGIDWIDTH-1:0] dst, input logic [NUMLANES-1:0] mask,
                              input logic [NUMLANES*WIDTH-1:0] data);
        wr_t w;
        for (int g = 0; g < NUMGROUPS; g++) begin
            if (mask[g*NUMWBLANES +: NUMWBLANES] != '0) begin
                w.dst  = dst;
                w.grp  = GRPIDW'(g);
                w.mask = mask[g*NUMWBLANES +: NUMWBLANES];
                w.data = data[g*GW +: GW];
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [REGIDWIDTH-1:0] dst,
                                 input logic [NUMLANES-1:0] mask, input logic [NUMLANES*WIDTH-1:0] data);
        in_valid  = v;
        in_dst    = dst;
        in_mask   = mask;
        in_result = data;
    endtask

    task automatic checkOutput(input string tag);
        wr_t w;
        if (exp_q.size() > 0) begin
            w = exp_q[0];
            check_eq({tag, " wb_we"}, GW'(wb_we), GW'(1'b1));
            check_eq({tag, " wb_dst"}, GW'(wb_dst), GW'(w.dst));
            check_eq({tag, " wb_group"}, GW'(wb_group), GW'(w.grp));
            check_eq({tag, " wb_mask"}, GW'(wb_mask), GW'(w.mask));
            check_eq({tag, " wb_data"}, wb_data, w.data);
        end else begin
            check_eq({tag, " wb_we"}, GW'(wb_we), '0);
            check_eq({tag, " wb_dst"}, GW'(wb_dst), '0);
            check_eq({tag, " wb_group"}, GW'(wb_group), '0);
            check_eq({tag, " wb_mask"}, GW'(wb_mask), '0);
            check_eq({tag, " wb_data"}, wb_data, '0);
        end
        check_eq({tag, " stall"}, GW'(stall), GW'(exp_q.size() > 1));
        check_eq({tag, " busy"}, GW'(busy), GW'(exp_q.size() > 0));
    endtask

    // Advance the model over one edge using the inputs present at that edge,
    // then compare the DUT just after the edge
    task automatic cycle(input string tag);
        wr_t tmp;
        bit  mstall;
        mstall = (exp_q.size() > 1);
        accepted_last = 0;
        if (!resetn || flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) tmp = exp_q.pop_front();
            if (in_valid && !mstall) begin
                accepted_last = 1;
                model_push(in_dst, in_mask, in_result);
            end
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [NUMLANES*WIDTH-1:0] lane_index_data(input int base);
        logic [NUMLANES*WIDTH-1:0] d;
        for (int i = 0; i < NUMLANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'(base + i);
        return d;
    endfunction

    function automatic logic [NUMLANES*WIDTH-1:0] random_data();
        logic [NUMLANES*WIDTH-1:0] d;
        for (int i = 0; i < NUMLANES; i++) d[i*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    initial begin
        logic [REGIDWIDTH-1:0] dsts[8];
        logic [GW-1:0]         grp2_data;
        logic [NUMLANES-1:0]   m;

        // Reset
        resetn = 1'b0;
        flush  = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        cycle("reset0");
        cycle("reset1");
        check_eq("reset stall", GW'(stall), '0);
        check_eq("reset busy", GW'(busy), '0);
        resetn = 1'b1;
        cycle("idle");

        // Full mask, lane i carries i
        applyStimulus(1'b1, 4'd5, 16'hFFFF, lane_index_data(0));
        cycle("full acc");
        applyStimulus(1'b0, '0, '0, '0);
        check_eq("full g0 group", GW'(wb_group), GW'(0));
        check_eq("full g0 stall", GW'(stall), GW'(1));
        cycle("full g1");
        cycle("full g2");
        grp2_data = {32'd11, 32'd10, 32'd9, 32'd8};
        check_eq("full g2 data", wb_data, grp2_data);
        check_eq("full g2 mask", GW'(wb_mask), GW'(4'hF));
        check_eq("full g2 dst", GW'(wb_dst), GW'(5));
        cycle("full g3");
        check_eq("full g3 stall", GW'(stall), GW'(0));
        check_eq("full g3 we", GW'(wb_we), GW'(1));
        cycle("full done");

        // Sparse mask: groups 0 and 2 only
        applyStimulus(1'b1, 4'd9, 16'h0F01, random_data());
        cycle("sparse acc");
        applyStimulus(1'b0, '0, '0, '0);
        check_eq("sparse w0 group", GW'(wb_group), GW'(0));
        check_eq("sparse w0 mask", GW'(wb_mask), GW'(4'h1));
        check_eq("sparse w0 stall", GW'(stall), GW'(1));
        cycle("sparse w1");
        check_eq("sparse w1 group", GW'(wb_group), GW'(2));
        check_eq("sparse w1 mask", GW'(wb_mask), GW'(4'hF));
        check_eq("sparse w1 stall", GW'(stall), GW'(0));
        cycle("sparse done");
        check_eq("sparse done we", GW'(wb_we), '0);

        // Empty mask, then a vector the very next cycle
        applyStimulus(1'b1, 4'd2, 16'h0000, random_data());
        cycle("empty");
        check_eq("empty we", GW'(wb_we), '0);
        check_eq("empty busy", GW'(busy), '0);
        applyStimulus(1'b1, 4'd4, 16'h00F0, random_data());
        cycle("after empty");
        check_eq("after empty group", GW'(wb_group), GW'(1));
        check_eq("after empty we", GW'(wb_we), GW'(1));
        applyStimulus(1'b0, '0, '0, '0);
        cycle("after empty done");

        // Back-to-back: second vector held while stalled
        applyStimulus(1'b1, 4'd3, 16'hFFFF, random_data());
        cycle("b2b 0");
        dsts[0] = wb_dst;
        check_eq("b2b we 0", GW'(wb_we), GW'(1));
        applyStimulus(1'b1, 4'd7, 16'hFFFF, random_data());
        for (int k = 1; k < 8; k++) begin
            cycle("b2b");
            dsts[k] = wb_dst;
            check_eq("b2b we", GW'(wb_we), GW'(1));
            if (accepted_last != 0) in_valid = 1'b0;
        end
        check_eq("b2b dst3", GW'(dsts[3]), GW'(3));
        check_eq("b2b dst4", GW'(dsts[4]), GW'(7));
        check_eq("b2b last group", GW'(wb_group), GW'(3));
        applyStimulus(1'b0, '0, '0, '0);
        cycle("b2b done");

        // Flush while group 1 is being written
        applyStimulus(1'b1, 4'd9, 16'hFFFF, random_data());
        cycle("flush g0");
        applyStimulus(1'b0, '0, '0, '0);
        cycle("flush g1");
        check_eq("flush g1 group", GW'(wb_group), GW'(1));
        flush = 1'b1;
        cycle("flush edge");
        check_eq("flush we", GW'(wb_we), '0);
        check_eq("flush busy", GW'(busy), '0);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) cycle("post flush");

        // Reset mid-drain, then a fresh vector
        applyStimulus(1'b1, 4'd6, 16'hFFFF, random_data());
        cycle("rst g0");
        applyStimulus(1'b0, '0, '0, '0);
        cycle("rst g1");
        resetn = 1'b0;
        cycle("rst edge");
        check_eq("rst we", GW'(wb_we), '0);
        check_eq("rst data", wb_data, '0);
        resetn = 1'b1;
        applyStimulus(1'b1, 4'd10, 16'h8001, random_data());
        cycle("fresh acc");
        applyStimulus(1'b0, '0, '0, '0);
        for (int k = 0; k < 3; k++) cycle("fresh drain");

        // Random traffic; upstream holds its vector while the model says stall
        for (int n = 0; n < 400; n++) begin
            if (!(in_valid && exp_q.size() > 1)) begin
                m = 16'($urandom);
                for (int g = 0; g < NUMGROUPS; g++) begin
                    if ($urandom_range(0, 2) == 0) m[g*NUMWBLANES +: NUMWBLANES] = '0;
                end
                applyStimulus(($urandom_range(0, 9) < 7), REGIDWIDTH'($urandom), m, random_data());
            end
            flush  = ($urandom_range(0, 19) == 0);
            resetn = ($urandom_range(0, 49) != 0);
            cycle("random");
        end

        resetn = 1'b1;
        flush  = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        for (int k = 0; k < 5; k++) cycle("drain out");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
